q_requant_drain: RTL and testbench
==================================

Q_REQUANT_DRAIN -- requirements
Module: q_requant_drain

Interface
REQ-001 Parameter N, default 4: tile dimension (N x N elements).
REQ-002 Parameter ACC_WIDTH, default 32: signed accumulator element width.
REQ-003 Parameter OUT_WIDTH, default 8: signed output element width.
REQ-004 Parameter SCALE_WIDTH, default 16: signed requant multiplier width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 in_valid  input  1  upstream tile available.
REQ-008 in_ready  output  1  block can accept a tile.
REQ-009 in_tile  input  N*N*ACC_WIDTH  element (r,c) at bits [(r*N+c)*ACC_WIDTH +: ACC_WIDTH].
REQ-010 scale  input  SCALE_WIDTH  signed multiplier, sampled at tile accept.
REQ-011 shift  input  5  right-shift amount 0..31, sampled at tile accept.
REQ-012 out_valid  output  1  out_row holds a valid quantized row.
REQ-013 out_ready  input  1  downstream accepts the row.
REQ-014 out_row  output  N*OUT_WIDTH  lane c at bits [c*OUT_WIDTH +: OUT_WIDTH].
REQ-015 out_row_idx  output  2  row number 0..N-1 of out_row.
REQ-016 out_last  output  1  high with out_valid on row N-1.
REQ-017 out_sat  output  1  high with out_valid when any lane of that row saturated.

Function
REQ-018 States: IDLE, RUN. in_ready SHALL be 1 only in IDLE.
REQ-019 Accept = in_valid & in_ready; on accept, tile, scale and shift are registered and the state goes to RUN.
REQ-020 in_valid in RUN SHALL be ignored; no tile is lost or overwritten.
REQ-021 Per element: 48-bit signed product p = elem*scale; if shift>0, p += 1<<(shift-1); q = p >>> shift (arithmetic).
REQ-022 q > 2^(OUT_WIDTH-1)-1 SHALL clamp to 127; q < -2^(OUT_WIDTH-1) SHALL clamp to -128; either clamp sets that row's out_sat.
REQ-023 Two-stage pipeline: stage 1 registers the products and rounding for one row; stage 2 registers saturated out_row, idx, last, sat.
REQ-024 First out_valid SHALL rise two cycles after the accept edge.
REQ-025 With out_ready held high, rows 0..N-1 SHALL issue one per cycle, in order.
REQ-026 While out_valid & !out_ready, out_row, out_row_idx, out_last and out_sat SHALL hold stable and stage 1 SHALL stall if full.
REQ-027 On the handshake of the row with out_last=1, state returns to IDLE; in_ready = 1 on the next cycle.
REQ-028 shift=0 SHALL apply no rounding term; scale=0 SHALL yield all-zero rows with out_sat=0.

Reset
REQ-029 While rst=1: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_sat=0, out_row=0, out_row_idx=0, pipeline valids cleared.
REQ-030 rst asserted mid-tile SHALL discard the in-flight tile; no partial rows after release.

Configuration
REQ-031 Macro Q_REQUANT_RELU_EN defined: negative q SHALL be forced to 0 before saturation (does not set out_sat); undefined: signed output as in REQ-022.

Structure
REQ-032 Package q_proj_pkg SHALL hold N, ACC_WIDTH, OUT_WIDTH, SCALE_WIDTH, typedefs acc_t, q_t, scale_t and the state enum.
REQ-033 Sub-module q_requant_lane (multiply, round, shift, saturate, sat flag) SHALL be instantiated N times.

Verification
REQ-034 All elements 1000, scale 1, shift 3, out_ready=1 -> four rows of 0x7D7D7D7D, idx 0..3, out_last on idx 3, first out_valid 2 cycles after accept.
REQ-035 Row 0 = {2000,-5000,127,-128}, scale 1, shift 0 -> lanes 0x7F,0x80,0x7F,0x80, out_sat=1 on row 0, 0 on other rows (elements 0).
REQ-036 Elements 12 and -12, scale 1, shift 3 -> 0x02 and 0xFF.
REQ-037 out_ready low 5 cycles after row 1 valid, in_valid pulsed meanwhile -> row 1 stable, in_ready=0, rows 2..3 follow in order, pulsed tile not accepted.
REQ-038 rst pulse after row 1 handshake -> out_valid=0 within the reset, in_ready=1, no rows 2..3 emitted after release.
REQ-039 Element -300, scale 1, shift 0 -> 0x00 with Q_REQUANT_RELU_EN, 0x80 and out_sat=1 without.

Source files
------------

// File: rtl/q_proj_pkg.sv
// ---------------------------------------------------------------------------
// q_proj_pkg
// Shared configuration for the requantise/drain slice: default tile and
// element widths, the signed element typedefs and the controller state type.
//
// Optional build macro (consumed by q_requant_lane):
//   Q_REQUANT_RELU_EN  - clamp negative results to zero before saturation.
// ---------------------------------------------------------------------------
package q_proj_pkg;

    localparam int N           = 4;   // tile is N x N elements
    localparam int ACC_WIDTH   = 32;  // signed accumulator element
    localparam int OUT_WIDTH   = 8;   // signed quantised element
    localparam int SCALE_WIDTH = 16;  // signed requant multiplier
    localparam int SHIFT_WIDTH = 5;   // right-shift amount 0..31
    localparam int IDX_WIDTH   = 2;   // row index width on the output port

    typedef logic signed [ACC_WIDTH-1:0]   acc_t;
    typedef logic signed [OUT_WIDTH-1:0]   q_t;
    typedef logic signed [SCALE_WIDTH-1:0] scale_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : q_proj_pkg

// File: rtl/q_requant_lane.sv
// ---------------------------------------------------------------------------
// q_requant_lane
// One output lane of the requantiser. Stage 1 (registered here) holds the
// full-width product of element and scale with the rounding term already
// added. The arithmetic shift and saturation are combinational on that
// register; the parent registers the result as stage 2.
//
// Optional build macro:
//   Q_REQUANT_RELU_EN  - negative shifted values become 0 before
//                        saturation; this never raises o_sat.
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : capture a new element into stage 1
//   i_elem    : signed accumulator element
//   i_scale   : signed multiplier
//   i_shift   : right-shift amount (also selects the rounding term)
//   o_q       : saturated signed result for the held element
//   o_sat     : o_q was clamped to the output range
// ---------------------------------------------------------------------------
module q_requant_lane #(
    parameter int ACC_WIDTH   = q_proj_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH   = q_proj_pkg::OUT_WIDTH,
    parameter int SCALE_WIDTH = q_proj_pkg::SCALE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [ACC_WIDTH-1:0]   i_elem,
    input  logic [SCALE_WIDTH-1:0] i_scale,
    input  logic [4:0]             i_shift,
    output logic [OUT_WIDTH-1:0]   o_q,
    output logic                   o_sat
);

    localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH;

    // Output range expressed at product width so the compares stay signed.
    localparam logic signed [PROD_W-1:0] Q_MAX =
        {{(PROD_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] Q_MIN = ~Q_MAX;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_rnd;
    logic signed [PROD_W-1:0] r_p;
    logic signed [PROD_W-1:0] w_q;
    logic signed [PROD_W-1:0] w_clip;

    assign w_prod = PROD_W'($signed(i_elem)) * PROD_W'($signed(i_scale));

    // Round-half-up term; a zero shift adds nothing.
    assign w_rnd = (i_shift == 5'd0) ? '0
                                     : (PROD_W'(1) << (i_shift - 5'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p <= '0;
        end else if (i_load) begin
            r_p <= w_prod + w_rnd;
        end
    end

    assign w_q = r_p >>> i_shift;

    always_comb begin
        w_clip = w_q;
`ifdef Q_REQUANT_RELU_EN
        if (w_q[PROD_W-1]) begin
            w_clip = '0;
        end
`endif
    end

    always_comb begin
        o_q   = w_clip[OUT_WIDTH-1:0];
        o_sat = 1'b0;
        if (w_clip > Q_MAX) begin
            o_q   = Q_MAX[OUT_WIDTH-1:0];
            o_sat = 1'b1;
        end else if (w_clip < Q_MIN) begin
            o_q   = Q_MIN[OUT_WIDTH-1:0];
            o_sat = 1'b1;
        end
    end

endmodule : q_requant_lane

// File: rtl/q_requant_drain.sv
// ---------------------------------------------------------------------------
// q_requant_drain
// Accepts an N x N tile of signed accumulators with a scale and shift,
// then drains it one requantised row per cycle through a two-stage
// pipeline (stage 1: products + rounding, stage 2: saturated row).
// A new tile is accepted only in IDLE; the controller returns to IDLE on
// the handshake of the last row.
//
// Optional build macro (see q_requant_lane):
//   Q_REQUANT_RELU_EN  - negative results clamp to zero.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : tile offered upstream
//   in_ready     : tile can be accepted (IDLE only)
//   in_tile      : element (r,c) at [(r*N+c)*ACC_WIDTH +: ACC_WIDTH]
//   scale, shift : requant parameters, captured with the tile
//   out_valid    : out_row holds a quantised row
//   out_ready    : downstream takes the row
//   out_row      : lane c at [c*OUT_WIDTH +: OUT_WIDTH]
//   out_row_idx  : row number of out_row
//   out_last     : out_row is row N-1
//   out_sat      : at least one lane of out_row was clamped
// ---------------------------------------------------------------------------
module q_requant_drain #(
    parameter int N           = q_proj_pkg::N,
    parameter int ACC_WIDTH   = q_proj_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH   = q_proj_pkg::OUT_WIDTH,
    parameter int SCALE_WIDTH = q_proj_pkg::SCALE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*N*ACC_WIDTH-1:0]   in_tile,
    input  logic [SCALE_WIDTH-1:0]     scale,
    input  logic [4:0]                 shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*OUT_WIDTH-1:0]     out_row,
    output logic [1:0]                 out_row_idx,
    output logic                       out_last,
    output logic                       out_sat
);

    import q_proj_pkg::*;

    localparam logic [1:0] LAST_ROW = 2'(N - 1);

    state_t                     r_state;
    logic [N*N*ACC_WIDTH-1:0]   r_tile;
    logic [SCALE_WIDTH-1:0]     r_scale;
    logic [4:0]                 r_shift;

    // Row issue: next row to enter stage 1 and whether any remain.
    logic [1:0]                 r_issue_row;
    logic                       r_issue_busy;

    // Stage 1 sideband (the lane registers hold the data).
    logic                       r_s1_valid;
    logic [1:0]                 r_s1_idx;
    logic                       r_s1_last;

    // Stage 2 / output registers.
    logic                       r_out_valid;
    logic [N*OUT_WIDTH-1:0]     r_out_row;
    logic [1:0]                 r_out_idx;
    logic                       r_out_last;
    logic                       r_out_sat;

    logic                       w_accept;
    logic                       w_out_fire;
    logic                       w_s2_load;
    logic                       w_s1_load;
    logic [N*ACC_WIDTH-1:0]     w_row_slice;
    logic [N*OUT_WIDTH-1:0]     w_row_q;
    logic [N-1:0]               w_lane_sat;

    assign in_ready   = (r_state == ST_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Stage 2 refills when it is empty or being drained this cycle;
    // stage 1 refills when it is empty or moving into stage 2.
    assign w_s2_load  = r_s1_valid & (~r_out_valid | out_ready);
    assign w_s1_load  = r_issue_busy & (~r_s1_valid | w_s2_load);

    assign w_row_slice = r_tile[r_issue_row*(N*ACC_WIDTH) +: N*ACC_WIDTH];

    // Controller and captured tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tile  <= '0;
            r_scale <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            r_state <= ST_RUN;
            r_tile  <= in_tile;
            r_scale <= scale;
            r_shift <= shift;
        end else if ((r_state == ST_RUN) && w_out_fire && r_out_last) begin
            r_state <= ST_IDLE;
        end
    end

    // Row issue counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_row  <= '0;
            r_issue_busy <= 1'b0;
        end else if (w_accept) begin
            r_issue_row  <= '0;
            r_issue_busy <= 1'b1;
        end else if (w_s1_load) begin
            r_issue_row <= r_issue_row + 2'd1;
            if (r_issue_row == LAST_ROW) begin
                r_issue_busy <= 1'b0;
            end
        end
    end

    // Stage 1 sideband.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_idx   <= r_issue_row;
            r_s1_last  <= (r_issue_row == LAST_ROW);
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    genvar g_c;
    generate
        for (g_c = 0; g_c < N; g_c++) begin : g_lane
            q_requant_lane #(
                .ACC_WIDTH   (ACC_WIDTH),
                .OUT_WIDTH   (OUT_WIDTH),
                .SCALE_WIDTH (SCALE_WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_s1_load),
                .i_elem  (w_row_slice[g_c*ACC_WIDTH +: ACC_WIDTH]),
                .i_scale (r_scale),
                .i_shift (r_shift),
                .o_q     (w_row_q[g_c*OUT_WIDTH +: OUT_WIDTH]),
                .o_sat   (w_lane_sat[g_c])
            );
        end
    endgenerate

    // Stage 2: holds while out_valid & !out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_row   <= w_row_q;
            r_out_idx   <= r_s1_idx;
            r_out_last  <= r_s1_last;
            r_out_sat   <= |w_lane_sat;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_row     = r_out_row;
    assign out_row_idx = r_out_idx;
    assign out_last    = r_out_last;
    assign out_sat     = r_out_sat;

endmodule : q_requant_drain

// File: tb/tb_q_requant_drain.sv
// ---------------------------------------------------------------------------
// tb_q_requant_drain
// Directed and randomised tiles against a plain-arithmetic reference of the
// requantisation rules; rows are checked at every output handshake.
// ---------------------------------------------------------------------------
module tb_q_requant_drain;

    import q_proj_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [N*N*ACC_WIDTH-1:0]   in_tile;
    logic [SCALE_WIDTH-1:0]     scale;
    logic [4:0]                 shift;
    logic                       out_valid;
    logic                       out_ready;
    logic [N*OUT_WIDTH-1:0]     out_row;
    logic [1:0]                 out_row_idx;
    logic                       out_last;
    logic                       out_sat;

    int n_asserts = 0;
    int n_fail    = 0;

    int                     elems [N*N];
    int                     t_scale;
    int                     t_shift;
    logic [N*OUT_WIDTH-1:0] exp_row [N];
    logic                   exp_sat [N];

    always #5 clk = ~clk;

    q_requant_drain #(
        .N           (N),
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SCALE_WIDTH (SCALE_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tile     (in_tile),
        .scale       (scale),
        .shift       (shift),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .out_sat     (out_sat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {sat, q} for one element, straight from the arithmetic rules.
    function automatic logic [8:0] ref_q(input longint e, input longint s, input int sh);
        longint p;
        longint q;
        p = e * s;
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
        q = p >>> sh;
`ifdef Q_REQUANT_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 127)  return {1'b1, 8'h7F};
        if (q < -128) return {1'b1, 8'h80};
        return {1'b0, q[7:0]};
    endfunction

    task automatic build_model();
        logic [8:0] v;
        for (int r = 0; r < N; r++) begin
            exp_row[r] = '0;
            exp_sat[r] = 1'b0;
            for (int c = 0; c < N; c++) begin
                v = ref_q(longint'(elems[r*N+c]), longint'(t_scale), t_shift);
                exp_row[r][c*8 +: 8] = v[7:0];
                exp_sat[r] = exp_sat[r] | v[8];
            end
        end
    endtask

    task automatic load_inputs();
        for (int i = 0; i < N*N; i++) in_tile[i*ACC_WIDTH +: ACC_WIDTH] = elems[i];
        scale = t_scale[SCALE_WIDTH-1:0];
        shift = t_shift[4:0];
    endtask

    // mode 0: out_ready high; 1: random out_ready; 2: 5-cycle stall on row 1
    // with an in_valid pulse during the stall.
    task automatic run_tile(input string name, input int mode);
        int lat;
        int k;
        int cyc;
        int stall;
        bit stall_done;
        bit hold;
        logic [N*OUT_WIDTH-1:0] h_row;
        logic [1:0] h_idx;
        logic h_last;
        logic h_sat;
        build_model();
        load_inputs();
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({name, ":accept_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid   = 1'b0;
        lat        = -1;
        k          = 0;
        cyc        = 0;
        stall      = 0;
        stall_done = 0;
        hold       = 0;
        while (k < N && cyc < 200) begin
            if (hold) begin
                check({name, ":hold_valid"}, out_valid, 1);
                check({name, ":hold_row"}, out_row, h_row);
                check({name, ":hold_idx"}, out_row_idx, h_idx);
                check({name, ":hold_last"}, out_last, h_last);
                check({name, ":hold_sat"}, out_sat, h_sat);
            end
            if (out_valid && lat < 0) lat = cyc;
            check({name, ":busy_in_ready"}, in_ready, 0);
            if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                if (!stall_done && stall == 0 && out_valid && out_row_idx == 2'd1) stall = 5;
                if (stall > 0) begin
                    out_ready = 1'b0;
                    in_valid  = (stall == 3 || stall == 2);
                    in_tile   = ~in_tile;
                    stall--;
                    if (stall == 0) stall_done = 1;
                end else begin
                    out_ready = 1'b1;
                    in_valid  = 1'b0;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                check({name, ":row"}, out_row, exp_row[k]);
                check({name, ":idx"}, out_row_idx, k[1:0]);
                check({name, ":last"}, out_last, (k == N-1));
                check({name, ":sat"}, out_sat, exp_sat[k]);
                k++;
            end
            hold   = out_valid && !out_ready;
            h_row  = out_row;
            h_idx  = out_row_idx;
            h_last = out_last;
            h_sat  = out_sat;
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, ":rows_drained"}, k, N);
        check({name, ":ready_after_last"}, in_ready, 1);
        check({name, ":no_extra_row"}, out_valid, 0);
        if (mode == 0) check({name, ":first_valid_latency"}, lat, 2);
        if (mode == 2) begin
            check({name, ":stall_happened"}, stall_done, 1);
            repeat (4) begin
                @(negedge clk);
                check({name, ":pulsed_tile_dropped"}, out_valid, 0);
            end
        end
    endtask

    task automatic rand_elems();
        for (int i = 0; i < N*N; i++) elems[i] = int'($urandom) >>> $urandom_range(0, 31);
    endtask

    initial begin
        int k;
        int cyc;
        logic signed [15:0] s16;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_tile   = '0;
        scale     = '0;
        shift     = '0;
        repeat (2) @(negedge clk);
        check("rst:in_ready", in_ready, 1);
        check("rst:out_valid", out_valid, 0);
        check("rst:out_last", out_last, 0);
        check("rst:out_sat", out_sat, 0);
        check("rst:out_row", out_row, 0);
        check("rst:out_row_idx", out_row_idx, 0);
        rst = 1'b0;

        // All 1000, scale 1, shift 3 -> 0x7D everywhere.
        foreach (elems[i]) elems[i] = 1000;
        t_scale = 1; t_shift = 3;
        run_tile("round_1000", 0);
        check("round_1000:row_const", exp_row[0], 32'h7D7D7D7D);

        // Saturation on row 0 only.
        foreach (elems[i]) elems[i] = 0;
        elems[0] = 2000; elems[1] = -5000; elems[2] = 127; elems[3] = -128;
        t_scale = 1; t_shift = 0;
        run_tile("sat_row0", 0);

        // Rounding of +/-12 by 8.
        foreach (elems[i]) elems[i] = (i % 2 == 0) ? 12 : -12;
        t_scale = 1; t_shift = 3;
        run_tile("round_pm12", 0);

        // Backpressure stall with ignored in_valid pulse.
        rand_elems();
        s16 = 16'($urandom); t_scale = s16; t_shift = $urandom_range(0, 31);
        run_tile("stall", 2);

        // Reset after the row 1 handshake discards the tile.
        rand_elems();
        t_scale = 3; t_shift = 20;
        build_model();
        load_inputs();
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 2 && cyc < 50) begin
            if (out_valid && out_ready) begin
                check("rst_mid:row", out_row, exp_row[k]);
                k++;
            end
            cyc++;
            if (k < 2) @(negedge clk);
        end
        check("rst_mid:reached_row1", k, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid:out_valid", out_valid, 0);
        check("rst_mid:in_ready", in_ready, 1);
        check("rst_mid:out_row", out_row, 0);
        check("rst_mid:out_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid:no_rows_after", out_valid, 0);
        end
        check("rst_mid:idle_ready", in_ready, 1);

        // Negative element: ReLU build gives 0, plain build saturates.
        foreach (elems[i]) elems[i] = -300;
        t_scale = 1; t_shift = 0;
        run_tile("neg300", 0);
`ifdef Q_REQUANT_RELU_EN
        check("neg300:row_const", exp_row[0], 32'h00000000);
`else
        check("neg300:row_const", exp_row[0], 32'h80808080);
`endif

        // Zero scale.
        rand_elems();
        t_scale = 0; t_shift = $urandom_range(0, 31);
        run_tile("scale0", 0);

        // Random tiles with random backpressure.
        for (int t = 0; t < 8; t++) begin
            rand_elems();
            s16 = 16'($urandom); t_scale = s16;
            t_shift = $urandom_range(0, 31);
            run_tile("random", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_q_requant_drain
